// File: rtl/conv_complex_arbiter.sv
// Two-requester front end for a shared conv_complex core: round-robin job pick,
// operand hold while the core runs, watchdog abort, and a valid/ready result port.
module conv_complex_arbiter #(
    parameter  int QI        = 4,
    parameter  int QF        = 4,
    parameter  int NUM_ELEMS = 3,
    parameter  int TIMEOUT   = 64,
    localparam int W         = QI + QF,
    localparam int KW        = 6 * W,
    localparam int SW        = 2 * W * NUM_ELEMS,
    localparam int CW        = 2 * W * (NUM_ELEMS + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [KW-1:0] req0_kernel,
    input  logic [SW-1:0] req0_signal,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [KW-1:0] req1_kernel,
    input  logic [SW-1:0] req1_signal,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [CW-1:0] rsp_conv,
    output logic          rsp_overflow,
    output logic          rsp_timeout,
    output logic          core_en,
    output logic [KW-1:0] core_kernel,
    output logic [SW-1:0] core_signal,
    input  logic [CW-1:0] core_conv,
    input  logic          core_overflow,
    input  logic          core_done,
    output logic          busy
);

    localparam int CNTW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, RELEASE, RESP} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNTW-1:0]   cnt;
    logic              last_grant;
    logic              sel;
    logic              grant;
    logic              cnt_max;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        sel = 1'b1;
        if (req0_valid && req1_valid)
            sel = ~last_grant;
        else if (req0_valid)
            sel = 1'b0;
    end

    assign grant   = (state_q == IDLE) && !rst && (sel ? req1_valid : req0_valid);
    assign cnt_max = (cnt == CNTW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // RELEASE waits for done to drop so a lingering done cannot finish the next job.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = RUN;
            RUN:     if (core_done || cnt_max) state_d = RELEASE;
            RELEASE: if (!core_done || cnt_max) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant && !sel;
        req1_ready = grant && sel;
        busy       = (state_q != IDLE);
        rsp_valid  = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            last_grant   <= 1'b1;
            core_en      <= 1'b0;
            core_kernel  <= '0;
            core_signal  <= '0;
            rsp_id       <= 1'b0;
            rsp_conv     <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        core_kernel <= sel ? req1_kernel : req0_kernel;
                        core_signal <= sel ? req1_signal : req0_signal;
                        rsp_id      <= sel;
                        last_grant  <= sel;
                        cnt         <= '0;
                        core_en     <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        rsp_conv     <= core_conv;
                        rsp_overflow <= core_overflow;
                        rsp_timeout  <= 1'b0;
                        core_en      <= 1'b0;
                        cnt          <= '0;
                    end else if (cnt_max) begin
                        rsp_conv     <= '0;
                        rsp_overflow <= 1'b0;
                        rsp_timeout  <= 1'b1;
                        core_en      <= 1'b0;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                RELEASE: cnt <= cnt + CNTW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_complex_arbiter.sv
// Directed bench for conv_complex_arbiter with a behavioural core model whose
// done delay, overflow and post-enable done hold are set per test.
module tb_conv_complex_arbiter;

    localparam int KW = 48;
    localparam int SW = 48;
    localparam int CW = 80;
    localparam logic [CW-1:0] GARBAGE = 80'h0BAD_0BAD_0BAD_0BAD_0BAD;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [KW-1:0] req0_kernel, req1_kernel, core_kernel;
    logic [SW-1:0] req0_signal, req1_signal, core_signal;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_timeout;
    logic [CW-1:0] rsp_conv, core_conv;
    logic          core_en, core_overflow, core_done, busy;

    conv_complex_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_kernel(req0_kernel), .req0_signal(req0_signal),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_kernel(req1_kernel), .req1_signal(req1_signal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_conv(rsp_conv), .rsp_overflow(rsp_overflow), .rsp_timeout(rsp_timeout),
        .core_en(core_en), .core_kernel(core_kernel), .core_signal(core_signal),
        .core_conv(core_conv), .core_overflow(core_overflow), .core_done(core_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Core stand-in result: a fixed rearrangement of the operands it was given.
    function automatic logic [CW-1:0] model(input logic [KW-1:0] k, input logic [SW-1:0] s);
        return {k[31:0], s};
    endfunction

    int  ccnt, dly, hold, stale_hold, cyc;
    int  t_acc, t_done, t_rsp, en_run, last_en_len, rel_run, last_rel_len;
    int  n_rsp, n_rdy0, both_rdy;
    bit  done_on, ovf_val, auto_drop, acc0, acc1, p_en, p_rel, p_rspv, fire;
    int  grants[$];
    logic          rq_id[$];
    logic          rq_ovf[$];
    logic          rq_to[$];
    logic [CW-1:0] rq_conv[$];

    // Called at a falling edge with inputs already set; samples, crosses one
    // rising edge and returns at the next falling edge with the core model advanced.
    task run_cycle();
        bit rel;
        #1;
        cyc++;
        if (req0_ready === 1'b1 && req1_ready === 1'b1) both_rdy++;
        if (req0_ready === 1'b1) begin grants.push_back(0); acc0 = 1; n_rdy0++; t_acc = cyc; end
        if (req1_ready === 1'b1) begin grants.push_back(1); acc1 = 1; t_acc = cyc; end
        if (core_en === 1'b1) en_run = p_en ? en_run + 1 : 1;
        else if (p_en) last_en_len = en_run;
        if (core_done && core_en === 1'b1) t_done = cyc;
        rel = (busy === 1'b1) && (core_en === 1'b0) && (rsp_valid === 1'b0);
        if (rel) rel_run = p_rel ? rel_run + 1 : 1;
        else if (p_rel) last_rel_len = rel_run;
        if (rsp_valid === 1'b1 && !p_rspv) t_rsp = cyc;
        if (rsp_valid === 1'b1 && rsp_ready) begin
            rq_id.push_back(rsp_id); rq_conv.push_back(rsp_conv);
            rq_ovf.push_back(rsp_overflow); rq_to.push_back(rsp_timeout);
            n_rsp++;
        end
        fire   = done_on && (core_en === 1'b1) && (ccnt == dly);
        p_en   = (core_en === 1'b1);
        p_rel  = rel;
        p_rspv = (rsp_valid === 1'b1);
        @(posedge clk);
        @(negedge clk);
        ccnt = p_en ? ccnt + 1 : 0;
        if (fire) hold = stale_hold;
        else if (hold > 0) hold--;
        if (acc0 && auto_drop) req0_valid = 1'b0;
        if (acc1 && auto_drop) req1_valid = 1'b0;
        acc0 = 0; acc1 = 0;
        core_done     = done_on && (((core_en === 1'b1) && ccnt == dly) || hold > 0);
        core_conv     = core_done ? model(core_kernel, core_signal) : GARBAGE;
        core_overflow = core_done ? ovf_val : 1'b0;
    endtask

    task wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && n_rsp < target; i++) run_cycle();
        check("rsp_arrived", 80'(n_rsp), 80'(target));
    endtask

    localparam logic [KW-1:0] KA = 48'h042012F000F4;
    localparam logic [SW-1:0] SA = 48'h11D0FA1428FC;
    localparam logic [KW-1:0] KB = 48'h7F0180FF1020;
    localparam logic [SW-1:0] SB = 48'hA5A55A5A0F0F;
    localparam logic [KW-1:0] KC = 48'h123456789ABC;
    localparam logic [SW-1:0] SC = 48'hFEDCBA987654;

    logic [CW-1:0] snap_conv;
    logic          snap_id, snap_ovf, snap_to;
    int            bad, g0, g1, n5, gi;

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_kernel = KA; req0_signal = SA; req1_kernel = KB; req1_signal = SB;
        core_done = 1'b0; core_conv = '0; core_overflow = 1'b0;
        done_on = 1; dly = 4; stale_hold = 0; ovf_val = 0; auto_drop = 1;
        ccnt = 0; hold = 0; cyc = 0; n_rsp = 0; n_rdy0 = 0; both_rdy = 0;
        @(negedge clk);
        run_cycle(); run_cycle();

        // reset state, with req0 already pending
        check("rst_core_en", 80'(core_en), 80'(0));
        check("rst_busy", 80'(busy), 80'(0));
        check("rst_rsp_valid", 80'(rsp_valid), 80'(0));
        check("rst_req0_ready", 80'(req0_ready), 80'(0));
        check("rst_core_ops", 80'({core_kernel, core_signal} != 96'd0), 80'(0));
        check("rst_rsp_data", {rsp_conv[76:0], rsp_id, rsp_overflow, rsp_timeout}, 80'(0));

        // test 1: single req0 job, done on 5th enable cycle
        n_rdy0 = 0;
        rst = 1'b0; rsp_ready = 1'b1;
        wait_rsp(1, 30);
        check("t1_ready_cycles", 80'(n_rdy0), 80'(1));
        check("t1_en_len", 80'(last_en_len), 80'(5));
        check("t1_done_to_rsp", 80'(t_rsp - t_done), 80'(2));
        check("t1_req_to_rsp", 80'(t_rsp - t_acc), 80'(7));
        check("t1_id", 80'(rq_id[$]), 80'(0));
        check("t1_conv", rq_conv[$], 80'h12F000F4_11D0FA1428FC);
        check("t1_flags", 80'({rq_ovf[$], rq_to[$]}), 80'(0));

        // test 2: both requesters pending continuously after a reset
        rst = 1'b1; run_cycle(); rst = 1'b0;
        grants.delete(); both_rdy = 0; auto_drop = 0; dly = 1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_rsp(5, 200);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("t2_grant_count", 80'(grants.size()), 80'(4));
        for (int i = 0; i < 4; i++) begin
            gi = (i < grants.size()) ? grants[i] : -1;
            check($sformatf("t2_grant%0d", i), 80'(gi), 80'(i % 2));
        end
        check("t2_both_ready", 80'(both_rdy), 80'(0));
        check("t2_rsp_ids", 80'({rq_id[1], rq_id[2], rq_id[3], rq_id[4]}), 80'(4'b0101));
        check("t2_conv_req1", rq_conv[2], model(KB, SB));
        run_cycle();

        // test 3: core never completes, watchdog aborts
        auto_drop = 1; done_on = 0;
        req1_kernel = KC; req1_signal = SC; req1_valid = 1'b1;
        wait_rsp(6, 200);
        done_on = 1;
        check("t3_en_len", 80'(last_en_len), 80'(64));
        check("t3_timeout", 80'(rq_to[$]), 80'(1));
        check("t3_conv", rq_conv[$], 80'(0));
        check("t3_ovf", 80'(rq_ovf[$]), 80'(0));
        check("t3_id", 80'(rq_id[$]), 80'(1));

        // test 4: response held back for 10 cycles
        rsp_ready = 1'b0; dly = 1; ovf_val = 1;
        req0_valid = 1'b1;
        for (int i = 0; i < 30 && rsp_valid !== 1'b1; i++) run_cycle();
        check("t4_rsp_valid", 80'(rsp_valid), 80'(1));
        snap_conv = rsp_conv; snap_id = rsp_id; snap_ovf = rsp_overflow; snap_to = rsp_timeout;
        req0_kernel = KB; req0_signal = SB; req1_kernel = KA; req1_signal = SA;
        req0_valid = 1'b1; req1_valid = 1'b1;
        g0 = grants.size(); bad = 0;
        for (int i = 0; i < 10; i++) begin
            run_cycle();
            if (rsp_conv !== snap_conv || rsp_id !== snap_id || rsp_overflow !== snap_ovf ||
                rsp_timeout !== snap_to || busy !== 1'b1 || rsp_valid !== 1'b1) bad++;
        end
        check("t4_stable", 80'(bad), 80'(0));
        check("t4_no_grant", 80'(grants.size()), 80'(g0));
        check("t4_conv", snap_conv, model(KA, SA));
        check("t4_ovf", 80'(snap_ovf), 80'(1));
        ovf_val = 0;

        // test 5: reset in the second RUN cycle
        rsp_ready = 1'b1; dly = 10; n5 = n_rsp;
        for (int i = 0; i < 6 && grants.size() == g0; i++) run_cycle();
        check("t5_grant_after_rsp", 80'(grants.size()), 80'(g0 + 1));
        check("t5_grant_req1", 80'(grants[$]), 80'(1));
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("t5_rst_outputs", 80'({core_en, rsp_valid, busy}), 80'(0));
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        g1 = grants.size();
        run_cycle();
        req1_valid = 1'b0;
        check("t5_post_rst_grant", 80'(grants.size()), 80'(g1 + 1));
        check("t5_post_rst_req0", 80'(grants[$]), 80'(0));
        wait_rsp(n5 + 2, 40);
        check("t5_rsp_id", 80'(rq_id[$]), 80'(0));
        check("t5_rsp_conv", rq_conv[$], model(KB, SB));

        // test 6: overflow with done lingering after enable drops
        run_cycle();
        dly = 2; ovf_val = 1; stale_hold = 2;
        req1_kernel = KC; req1_signal = SC; req1_valid = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        check("t6_ovf", 80'(rq_ovf[$]), 80'(1));
        check("t6_release_len", 80'(last_rel_len), 80'(3));
        check("t6_conv", rq_conv[$], model(KC, SC));
        run_cycle();
        dly = 3; ovf_val = 0; stale_hold = 0;
        req0_kernel = KA; req0_signal = SA; req0_valid = 1'b1;
        wait_rsp(n_rsp + 1, 40);
        check("t6_next_en_len", 80'(last_en_len), 80'(4));
        check("t6_next_conv", rq_conv[$], model(KA, SA));
        check("t6_next_flags", 80'({rq_id[$], rq_ovf[$], rq_to[$]}), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
